pe_array_sched: RTL and testbench

Wavefront scheduler for the N×N PE systolic array. It accepts one tile command (operand depth K plus the compute-type descriptor) and drives the array's west and north edge enables with the per-row and per-column one-cycle skew the array needs. It issues operand-buffer read indices, waits for the wavefront to drain, and runs a skewed compute-mode (cm) phase for INT4 tiles. It then pulses `done` and returns to idle. It sits between the tile-level command issuer and the array edge (`enleft`/`enup`/`cmleft`/`cmup`/`addr_type` of row 0 and column 0 PEs).

---
 rtl/pe_array_sched_pkg.sv | 34 +++
 rtl/pe_array_sched_skew_line.sv | 22 ++
 rtl/pe_array_sched.sv | 97 +++++++++
 tb/tb_pe_array_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pe_array_sched_pkg.sv
// Shared types for the systolic-array tile scheduler: compute-type descriptor,
// scheduler states and drain length.
package params;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } datatype_t;

  typedef struct packed {
    datatype_t  datatype;
    logic       transpose;
    logic [1:0] mode;
  } addrgen_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    DRAIN = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  localparam int DEF_N     = 4;
  localparam int DRAIN_LEN = 2 * DEF_N - 1;

  // Cycles for the last skewed pulse to leave an n x n array.
  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/pe_array_sched_skew_line.sv
// N-lane skew delay line: lane i is the 1-bit input delayed by i cycles.
// Lane 0 is a straight wire, so the input should already be a register. N >= 2.
module skew_line #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  output logic [N-1:0] dout
);

  logic [N-1:1] pipe;

  assign dout = {pipe, din};

  // NOTE: the delay taps are cleared on reset so no stale pulse can reach the array edge afterwards.
  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= dout[N-2:0];
  end

endmodule

// File: rtl/pe_array_sched.sv
// Wavefront scheduler: feeds K operand steps with per-lane skew to the array
// edges, drains the wavefront, runs a skewed cm phase for INT4, pulses done.
module pe_array_sched
  import params::*;
#(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          start_ready,
  input  logic [KW-1:0] k_len,
  input  addrgen_t      cfg,
  output logic          rd_req,
  output logic [KW-1:0] rd_k,
  output logic [N-1:0]  row_en,
  output logic [N-1:0]  col_en,
  output logic [N-1:0]  row_cm,
  output logic [N-1:0]  col_cm,
  output addrgen_t      type_out,
  output logic          busy,
  output logic          done
);

  localparam int DLEN = drain_len(N);
  localparam int CW   = $clog2(DLEN + 1);

  sched_state_t  state_q, state_d;
  logic [KW-1:0] k_last_q, rd_k_q;
  logic [CW-1:0] phase_q;
  addrgen_t      type_q;
  logic          rd_req_q, cm_pulse_q, done_q, busy_q, ready_q;
  logic          accept, phase_end;

  assign accept    = start & ready_q;
  assign phase_end = (phase_q == CW'(DLEN - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (k_len == '0) ? DONE : FEED;
      FEED:    if (rd_k_q == k_last_q) state_d = DRAIN;
      DRAIN:   if (phase_end) state_d = (type_q.datatype == INT4) ? CMP : DONE;
      CMP:     if (phase_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_last_q   <= '0;
      rd_k_q     <= '0;
      phase_q    <= '0;
      type_q     <= '0;
      rd_req_q   <= 1'b0;
      cm_pulse_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        k_last_q <= k_len - 1'b1;
        type_q   <= cfg;
      end
      rd_k_q <= (state_q == FEED && state_d == FEED) ? rd_k_q + 1'b1 : '0;
      if (state_d == state_q && (state_q == DRAIN || state_q == CMP))
        phase_q <= phase_q + 1'b1;
      else
        phase_q <= '0;
      rd_req_q   <= (state_d == FEED);
      cm_pulse_q <= (state_d == CMP) && (state_q != CMP);
      done_q     <= (state_d == DONE);
      busy_q     <= (state_d != IDLE);
      ready_q    <= (state_d == IDLE);
    end
  end

  skew_line #(.N(N)) u_row_en (.clk(clk), .rst(rst), .din(rd_req_q),   .dout(row_en));
  skew_line #(.N(N)) u_col_en (.clk(clk), .rst(rst), .din(rd_req_q),   .dout(col_en));
  skew_line #(.N(N)) u_row_cm (.clk(clk), .rst(rst), .din(cm_pulse_q), .dout(row_cm));
  skew_line #(.N(N)) u_col_cm (.clk(clk), .rst(rst), .din(cm_pulse_q), .dout(col_cm));

  assign start_ready = ready_q;
  assign rd_req      = rd_req_q;
  assign rd_k        = rd_k_q;
  assign type_out    = type_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pe_array_sched.sv
// Self-checking bench for pe_array_sched: table-driven tiles plus hand-written
// sequences for held start, cfg change while busy and reset mid-tile.
module tb_pe_array_sched;
  import params::*;

  localparam int N  = 4;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          start_ready;
  logic [KW-1:0] k_len = '0;
  addrgen_t      cfg = '0;
  logic          rd_req;
  logic [KW-1:0] rd_k;
  logic [N-1:0]  row_en, col_en, row_cm, col_cm;
  addrgen_t      type_out;
  logic          busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  pe_array_sched #(.N(N), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .k_len(k_len), .cfg(cfg), .rd_req(rd_req), .rd_k(rd_k),
    .row_en(row_en), .col_en(col_en), .row_cm(row_cm), .col_cm(col_cm),
    .type_out(type_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Cycle numbers: accept edge is cycle 0; cycle c is observed #1 after edge c-1.
  typedef struct {
    int        k;
    datatype_t dt;
    int        done_cyc;
    int        rd_cnt;
    int        en3_first;
    int        en3_last;
    int        cm0_cyc;
    int        cm3_cyc;
  } vec_t;

  task automatic run_vec(input vec_t v);
    addrgen_t     exp_type;
    logic [N-1:0] hist, cmh;
    int done_c = -1, rd_cnt = 0, rd_err = 0, skew_err = 0;
    int en3_f = -1, en3_l = -1, cm0 = -1, cm3 = -1, busy_cnt = 0, type_err = 0;
    exp_type = '{datatype: v.dt, transpose: 1'b1, mode: 2'd2};
    cfg   = exp_type;
    k_len = KW'(v.k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k_len = 8'd7;
    cfg   = '0;
    hist  = '0;
    cmh   = '0;
    for (int c = 1; c <= 400; c++) begin
      hist = {hist[N-2:0], rd_req};
      cmh  = {cmh[N-2:0], row_cm[0]};
      if (row_en !== hist || col_en !== hist || row_cm !== cmh || col_cm !== cmh) skew_err++;
      if (rd_req) begin
        if (rd_k !== KW'(rd_cnt)) rd_err++;
        rd_cnt++;
      end
      if (row_en[N-1]) begin
        if (en3_f < 0) en3_f = c;
        en3_l = c;
      end
      if (row_cm[0] && cm0 < 0) cm0 = c;
      if (row_cm[N-1] && cm3 < 0) cm3 = c;
      if (busy) busy_cnt++;
      if (type_out !== exp_type) type_err++;
      if (done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    check($sformatf("k%0d done_cycle", v.k), done_c, v.done_cyc);
    check($sformatf("k%0d rd_count", v.k), rd_cnt, v.rd_cnt);
    check($sformatf("k%0d rd_k_order_errs", v.k), rd_err, 0);
    check($sformatf("k%0d skew_errs", v.k), skew_err, 0);
    check($sformatf("k%0d row_en3_first", v.k), en3_f, v.en3_first);
    check($sformatf("k%0d row_en3_last", v.k), en3_l, v.en3_last);
    check($sformatf("k%0d row_cm0_cycle", v.k), cm0, v.cm0_cyc);
    check($sformatf("k%0d row_cm3_cycle", v.k), cm3, v.cm3_cyc);
    check($sformatf("k%0d busy_cycles", v.k), busy_cnt, v.done_cyc);
    check($sformatf("k%0d type_out_errs", v.k), type_err, 0);
    @(posedge clk); #1;
    check($sformatf("k%0d ready_after_done", v.k), int'(start_ready), 1);
    check($sformatf("k%0d done_is_pulse", v.k), int'(done), 0);
  endtask

  vec_t vecs[6];

  initial begin
    addrgen_t cfg_a, cfg_b;
    int       acc[$];
    int       terr, leak, idle_wait;
    logic     rdy_prev;

    vecs[0] = '{k: 3,   dt: FP32, done_cyc: 11,  rd_cnt: 3,   en3_first: 4,  en3_last: 6,   cm0_cyc: -1, cm3_cyc: -1};
    vecs[1] = '{k: 2,   dt: INT4, done_cyc: 17,  rd_cnt: 2,   en3_first: 4,  en3_last: 5,   cm0_cyc: 10, cm3_cyc: 13};
    vecs[2] = '{k: 0,   dt: FP16, done_cyc: 1,   rd_cnt: 0,   en3_first: -1, en3_last: -1,  cm0_cyc: -1, cm3_cyc: -1};
    vecs[3] = '{k: 5,   dt: INT8, done_cyc: 13,  rd_cnt: 5,   en3_first: 4,  en3_last: 8,   cm0_cyc: -1, cm3_cyc: -1};
    vecs[4] = '{k: 1,   dt: INT4, done_cyc: 16,  rd_cnt: 1,   en3_first: 4,  en3_last: 4,   cm0_cyc: 9,  cm3_cyc: 12};
    vecs[5] = '{k: 255, dt: FP32, done_cyc: 263, rd_cnt: 255, en3_first: 4,  en3_last: 258, cm0_cyc: -1, cm3_cyc: -1};

    // Reset values.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst start_ready", int'(start_ready), 1);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst rd_req", int'(rd_req), 0);
    check("rst rd_k", int'(rd_k), 0);
    check("rst enables", int'({row_en, col_en, row_cm, col_cm}), 0);
    check("rst type_out", int'(type_out), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // start held high: second accept only once the first tile has finished,
    // and cfg changed while busy is not seen until that second accept.
    cfg_a = '{datatype: FP16, transpose: 1'b0, mode: 2'd1};
    cfg_b = '{datatype: INT8, transpose: 1'b1, mode: 2'd3};
    cfg   = cfg_a;
    k_len = 8'd1;
    start = 1'b1;
    terr  = 0;
    rdy_prev = start_ready;
    for (int e = 0; e <= 12; e++) begin
      @(posedge clk);
      if (rdy_prev) acc.push_back(e);
      #1;
      if (e == 0) cfg = cfg_b;
      rdy_prev = start_ready;
      if (e < 10 && type_out !== cfg_a) terr++;
      if (e >= 10 && type_out !== cfg_b) terr++;
    end
    start = 1'b0;
    check("held accept_count", acc.size(), 2);
    check("held accept0_cycle", (acc.size() > 0) ? acc[0] : -1, 0);
    check("held accept1_cycle", (acc.size() > 1) ? acc[1] : -1, 10);
    check("held type_out_errs", terr, 0);
    idle_wait = 0;
    while (!start_ready && idle_wait < 50) begin
      @(posedge clk); #1;
      idle_wait++;
    end
    check("held returns_idle", int'(start_ready), 1);

    // Reset asserted during cycle 5 of a K=8 tile.
    cfg   = '{datatype: FP32, transpose: 1'b0, mode: 2'd0};
    k_len = 8'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("midrst row_en_active", int'(row_en != '0), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst enables", int'({row_en, col_en, row_cm, col_cm}), 0);
    check("midrst rd_req", int'(rd_req), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst start_ready", int'(start_ready), 1);
    leak = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if ({row_en, col_en, row_cm, col_cm} != '0 || rd_req || done || busy) leak++;
    end
    check("midrst leak_cycles", leak, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
